// File: rtl/secuenciador_ecualizador.sv
// -----------------------------------------------------------------------------
// secuenciador_ecualizador
// Sample-frame scheduler for the three-band equalizer. A period counter
// produces the sample tick. Each tick runs one ordered frame: serial ADC read,
// a one-cycle filter enable, a wait for filter latency, then a serial DAC
// write. Capture, filtering and playback therefore never overlap.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   inicio        in   run level; 1 = sample ticks generated
//   datoADCSerie  in   ADC serial data, MSB first
//   yk[11:0]      in   filtered word to send to the DAC
//   sclk          out  shared serial clock, idles 0
//   CS            out  ADC chip select, active low
//   CS_DAC        out  DAC chip select, active low
//   SalidaDelDAC  out  DAC serial data
//   dato_adc      out  last captured ADC sample
//   enable        out  one-cycle strobe to the filter bank
//   ocupado       out  high while a frame is in progress
//   sobrecarga    out  sticky overrun flag (tick arrived during a frame)
// -----------------------------------------------------------------------------
module secuenciador_ecualizador #(
  parameter int PERIODO    = 2268,
  parameter int DIV_SCLK   = 4,
  parameter int LAT_FILTRO = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic        datoADCSerie,
  input  logic [11:0] yk,
  output logic        sclk,
  output logic        CS,
  output logic        CS_DAC,
  output logic        SalidaDelDAC,
  output logic [11:0] dato_adc,
  output logic        enable,
  output logic        ocupado,
  output logic        sobrecarga
);

  localparam int CNT_W = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int PH_W  = (DIV_SCLK > 1) ? $clog2(DIV_SCLK) : 1;
  localparam int LAT_W = $clog2(LAT_FILTRO + 2);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIODO - 1);
  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(DIV_SCLK - 1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(LAT_FILTRO);

  typedef enum logic [2:0] {
    ESPERA,
    LEE_ADC,
    FILTRA,
    ESCRIBE_DAC,
    FIN
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  ph_q, ph_d;       // cycle within the current SCLK half period
  logic [4:0]       half_q, half_d;   // SCLK half-period index 0..31
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [11:0]      adc_sr_q, adc_sr_d;
  logic [11:0]      dato_q, dato_d;
  logic [15:0]      word_q, word_d;
  logic             sobre_q, sobre_d;

  logic tick;
  logic serie;
  logic fin_serie;
  logic flanco_sube;

  always_comb begin
    tick        = inicio && (cnt_q == CNT_MAX);
    serie       = (estado_q == LEE_ADC) || (estado_q == ESCRIBE_DAC);
    fin_serie   = (half_q == 5'd31) && (ph_q == PH_MAX);
    // First cycle of an SCLK-high half period.
    flanco_sube = half_q[0] && (ph_q == '0);
  end

  // Period counter: held at 0 while stopped, so the first tick comes a full
  // period after inicio rises.
  always_comb begin
    cnt_d = cnt_q;
    if (!inicio) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Serial timing counters run only during the two transfer states and wrap
  // back to zero exactly on the last transfer cycle.
  always_comb begin
    ph_d   = '0;
    half_d = '0;
    if (serie) begin
      half_d = half_q;
      if (ph_q == PH_MAX) begin
        ph_d   = '0;
        half_d = half_q + 5'd1;
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    lat_d    = '0;
    adc_sr_d = adc_sr_q;
    dato_d   = dato_q;
    word_d   = word_q;
    // Ticks that arrive mid-frame are dropped but remembered.
    sobre_d  = sobre_q | (tick && (estado_q != ESPERA));

    case (estado_q)
      ESPERA: begin
        if (tick) estado_d = LEE_ADC;
      end
      LEE_ADC: begin
        // The first four bits from the ADC are leading zeros (half periods 1,3,5,7).
        if (flanco_sube && (half_q >= 5'd9)) begin
          adc_sr_d = {adc_sr_q[10:0], datoADCSerie};
        end
        if (fin_serie) begin
          // Use the updated value so the final bit is kept even when DIV_SCLK=1.
          dato_d   = adc_sr_d;
          estado_d = FILTRA;
        end
      end
      FILTRA: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_MAX) begin
          word_d   = {4'b0000, yk};
          lat_d    = '0;
          estado_d = ESCRIBE_DAC;
        end
      end
      ESCRIBE_DAC: begin
        // Shift on the cycle before each rising SCLK from the second onward,
        // so the new bit appears together with the rising edge.
        if ((ph_q == PH_MAX) && !half_q[0] && (half_q >= 5'd2)) begin
          word_d = {word_q[14:0], 1'b0};
        end
        if (fin_serie) estado_d = FIN;
      end
      FIN: begin
        estado_d = ESPERA;
      end
      default: begin
        estado_d = ESPERA;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= ESPERA;
      cnt_q    <= '0;
      ph_q     <= '0;
      half_q   <= '0;
      lat_q    <= '0;
      adc_sr_q <= '0;
      dato_q   <= '0;
      word_q   <= '0;
      sobre_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      half_q   <= half_d;
      lat_q    <= lat_d;
      adc_sr_q <= adc_sr_d;
      dato_q   <= dato_d;
      word_q   <= word_d;
      sobre_q  <= sobre_d;
    end
  end

  // Outputs decode registered state only, so the asynchronous reset forces
  // them to idle values immediately.
  always_comb begin
    CS           = (estado_q != LEE_ADC);
    CS_DAC       = !((estado_q == ESCRIBE_DAC) || (estado_q == FIN));
    sclk         = serie && half_q[0];
    SalidaDelDAC = ((estado_q == ESCRIBE_DAC) || (estado_q == FIN)) && word_q[15];
    enable       = (estado_q == FILTRA) && (lat_q == '0);
    ocupado      = (estado_q != ESPERA);
    dato_adc     = dato_q;
    sobrecarga   = sobre_q;
  end

endmodule

// File: tb/tb_secuenciador_ecualizador.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_ecualizador
// Directed bench for the equalizer frame scheduler. Instance "dut" runs the
// default timing with a behavioural ADC (shifts on falling SCLK) and DAC
// (captures on falling SCLK). Instance "dut_ovr" uses a 200-cycle period,
// shorter than a frame, to exercise the overrun flag.
// -----------------------------------------------------------------------------
module tb_secuenciador_ecualizador;

  localparam int PER = 2268;
  localparam int D   = 4;
  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic        adc_sd;
  logic [11:0] yk;
  logic        sclk, cs, cs_dac, dac_sd, enable, ocupado, sobrecarga;
  logic [11:0] dato_adc;

  logic        inicio_b;
  logic [11:0] yk_b;
  logic        sclk_b, cs_b, cs_dac_b, dac_sd_b, enable_b, ocupado_b, sobrecarga_b;
  logic [11:0] dato_adc_b;

  always #5 clk = ~clk;

  secuenciador_ecualizador #(.PERIODO(PER), .DIV_SCLK(D), .LAT_FILTRO(LAT)) dut (
    .clock(clk), .reset(rst), .inicio(inicio), .datoADCSerie(adc_sd), .yk(yk),
    .sclk(sclk), .CS(cs), .CS_DAC(cs_dac), .SalidaDelDAC(dac_sd),
    .dato_adc(dato_adc), .enable(enable), .ocupado(ocupado), .sobrecarga(sobrecarga)
  );

  secuenciador_ecualizador #(.PERIODO(200), .DIV_SCLK(D), .LAT_FILTRO(LAT)) dut_ovr (
    .clock(clk), .reset(rst), .inicio(inicio_b), .datoADCSerie(1'b0), .yk(yk_b),
    .sclk(sclk_b), .CS(cs_b), .CS_DAC(cs_dac_b), .SalidaDelDAC(dac_sd_b),
    .dato_adc(dato_adc_b), .enable(enable_b), .ocupado(ocupado_b), .sobrecarga(sobrecarga_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- monitor / ADC + DAC models for dut ----------------
  int          cyc = 0;
  int          cs_fall_cnt = 0, last_fall = 0;
  int          adc_rise = 0, adc_last_rise = 0;
  int          en_cnt = 0, en_cyc = 0, en_len = 0;
  int          dac_low = 0, dac_edges = 0, dac_rise = 0, dac_fall_cyc = 0;
  int          dac_done = 0, dac_low_last = 0, dac_edges_last = 0, dac_rise_last = 0;
  logic [15:0] dac_sr = '0, dac_word = '0;
  logic [15:0] adc_word = '0;
  int          adc_bit = 0;
  logic        p_cs = 1'b1, p_csd = 1'b1, p_sclk = 1'b0, p_en = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (p_cs && !cs) begin
      cs_fall_cnt++;
      last_fall = cyc;
      adc_rise  = 0;
    end
    if (!cs && !p_sclk && sclk) adc_rise++;
    if (!p_cs && cs) adc_last_rise = adc_rise;
    if (enable) begin
      if (!p_en) begin
        en_cnt++;
        en_cyc = cyc;
        en_len = 0;
      end
      en_len++;
    end
    if (p_csd && !cs_dac) begin
      dac_low = 0; dac_edges = 0; dac_rise = 0; dac_sr = '0; dac_fall_cyc = cyc;
    end
    if (!cs_dac) begin
      dac_low++;
      if (!p_sclk && sclk) dac_rise++;
      if (p_sclk && !sclk) begin
        dac_sr = {dac_sr[14:0], dac_sd};
        dac_edges++;
      end
    end
    if (!p_csd && cs_dac) begin
      dac_done++;
      dac_word       = dac_sr;
      dac_low_last   = dac_low;
      dac_edges_last = dac_edges;
      dac_rise_last  = dac_rise;
    end
    // ADC model: bit k presented from CS fall, advanced on each falling SCLK.
    if (cs) adc_bit = 0;
    else if (p_sclk && !sclk && adc_bit < 15) adc_bit++;
    adc_sd = adc_word[15 - adc_bit];
    p_cs = cs; p_csd = cs_dac; p_sclk = sclk; p_en = enable;
  end

  // ---------------- monitor for dut_ovr ----------------
  int   b_adc_r = 0, b_dac_r = 0, b_xfers = 0, b_bad = 0;
  logic b_pcs = 1'b1, b_pcsd = 1'b1, b_psclk = 1'b0;

  always @(negedge clk) begin
    if (!cs_b && !b_psclk && sclk_b) b_adc_r++;
    if (!cs_dac_b && !b_psclk && sclk_b) b_dac_r++;
    if (!b_pcs && cs_b) begin
      b_xfers++;
      if (b_adc_r != 16) b_bad++;
      b_adc_r = 0;
    end
    if (!b_pcsd && cs_dac_b) begin
      b_xfers++;
      if (b_dac_r != 16) b_bad++;
      b_dac_r = 0;
    end
    b_pcs = cs_b; b_pcsd = cs_dac_b; b_psclk = sclk_b;
  end

  // ---------------- directed sequence ----------------
  int f, c0, c0b, prev_fall, dd, ec;

  initial begin
    rst = 1'b1; inicio = 1'b0; yk = 12'h123; inicio_b = 1'b0; yk_b = 12'h0;
    #1;
    check_eq("rst_async_cs", cs, 1);
    repeat (3) step();
    check_eq("rst_cs", cs, 1);
    check_eq("rst_cs_dac", cs_dac, 1);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_dac_sd", dac_sd, 0);
    check_eq("rst_enable", enable, 0);
    check_eq("rst_dato_adc", dato_adc, 0);
    check_eq("rst_sobrecarga", sobrecarga, 0);
    check_eq("rst_ocupado", ocupado, 0);

    // Idle with inicio=0 for 10000 cycles; overrun instance runs meanwhile.
    rst = 1'b0;
    inicio_b = 1'b1;
    c0b = cyc;
    f = cs_fall_cnt;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (cyc == c0b + 395) check_eq("ovr_before_2nd_tick", sobrecarga_b, 0);
      if (cyc == c0b + 405) check_eq("ovr_after_2nd_tick", sobrecarga_b, 1);
    end
    check_eq("idle_no_cs_fall", cs_fall_cnt - f, 0);
    check_eq("idle_ocupado", ocupado, 0);
    check_eq("ovr_sticky", sobrecarga_b, 1);
    check_eq("ovr_bad_transfers", b_bad, 0);
    check_eq("ovr_transfers_seen", (b_xfers >= 40), 1);

    // Single frame: ADC 0x0A5C, yk=0x3C5 presented exactly at the sampling cycle.
    adc_word = 16'h0A5C;
    inicio = 1'b1;
    c0 = cyc;
    f = cs_fall_cnt;
    for (int i = 0; i < 3000 && cs_fall_cnt == f; i++) step();
    check_eq("frame_cs_fall_seen", (cs_fall_cnt != f), 1);
    check_eq("first_tick_latency", last_fall - c0, PER);
    check_eq("frame_ocupado", ocupado, 1);
    ec = en_cnt;
    for (int i = 0; i < 300 && en_cnt == ec; i++) step();
    check_eq("enable_seen", (en_cnt != ec), 1);
    check_eq("enable_offset", en_cyc - last_fall, 32 * D);
    check_eq("dato_adc_at_enable", dato_adc, 12'hA5C);
    check_eq("adc_sclk_count", adc_last_rise, 16);
    repeat (LAT) step();
    yk = 12'h3C5;
    step();
    yk = 12'hFFF;
    dd = dac_done;
    for (int i = 0; i < 300 && dac_done == dd; i++) step();
    check_eq("dac_done_seen", (dac_done != dd), 1);
    check_eq("dac_word", dac_word, 16'h03C5);
    check_eq("dac_falling_edges", dac_edges_last, 16);
    check_eq("dac_sclk_count", dac_rise_last, 16);
    check_eq("cs_dac_low_len", dac_low_last, 32 * D + 1);
    check_eq("cs_dac_after_enable", dac_fall_cyc - en_cyc, LAT + 1);
    check_eq("enable_len", en_len, 1);
    check_eq("dato_adc_held", dato_adc, 12'hA5C);
    check_eq("dac_sd_idle", dac_sd, 0);
    check_eq("frame_sobrecarga", sobrecarga, 0);

    // Periodicity over five more frames.
    yk = 12'h2A7;
    for (int k = 0; k < 5; k++) begin
      prev_fall = last_fall;
      f = cs_fall_cnt;
      for (int i = 0; i < 2500 && cs_fall_cnt == f; i++) step();
      check_eq($sformatf("period_%0d", k), last_fall - prev_fall, PER);
      dd = dac_done;
      for (int i = 0; i < 300 && dac_done == dd; i++) step();
      check_eq($sformatf("period_word_%0d", k), dac_word, 16'h02A7);
    end
    check_eq("period_sobrecarga", sobrecarga, 0);

    // Drop inicio in the middle of ESCRIBE_DAC.
    f = cs_fall_cnt;
    for (int i = 0; i < 2500 && cs_fall_cnt == f; i++) step();
    for (int i = 0; i < 300 && cs_dac; i++) step();
    check_eq("drop_in_dac_write", cs_dac, 0);
    repeat (40) step();
    inicio = 1'b0;
    dd = dac_done;
    for (int i = 0; i < 300 && dac_done == dd; i++) step();
    check_eq("drop_dac_edges", dac_edges_last, 16);
    check_eq("drop_dac_word", dac_word, 16'h02A7);
    repeat (2) step();
    check_eq("drop_ocupado", ocupado, 0);
    f = cs_fall_cnt;
    repeat (3000) step();
    check_eq("drop_no_more_frames", cs_fall_cnt - f, 0);

    // Reset in LEE_ADC after 8 SCLKs.
    inicio = 1'b1;
    f = cs_fall_cnt;
    for (int i = 0; i < 2500 && cs_fall_cnt == f; i++) step();
    adc_word = 16'h0B7E;
    for (int i = 0; i < 200 && adc_rise < 8; i++) step();
    step();
    rst = 1'b1;
    #1;
    check_eq("midrst_cs", cs, 1);
    check_eq("midrst_sclk", sclk, 0);
    check_eq("midrst_dato_adc", dato_adc, 0);
    check_eq("midrst_ocupado", ocupado, 0);
    repeat (2) step();
    rst = 1'b0;
    f = cs_fall_cnt;
    for (int i = 0; i < 2500 && cs_fall_cnt == f; i++) step();
    ec = en_cnt;
    for (int i = 0; i < 300 && en_cnt == ec; i++) step();
    check_eq("postrst_dato_adc", dato_adc, 12'hB7E);
    check_eq("postrst_adc_sclks", adc_last_rise, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
